// File: rtl/vector_execute_unit_pkg.sv
// Shared types, constants and operand-select helper for the vector execute stage.
package vec_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned LANES = 16;
    localparam int unsigned SH_W  = $clog2(N);

    typedef logic [LANES-1:0][N-1:0] vec_t;

    typedef enum logic [2:0] {ADD, SUB, AND, OR, XOR, SHL, SHR, PASSB} alu_op_e;
    typedef enum logic [1:0] {SRC_REG, SRC_IMM, SRC_BIMM, SRC_BREG} alu_src_e;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic [3:0] wa3;
    } ctrl_t;

    function automatic vec_t select_b(alu_src_e src, vec_t rd2, vec_t ext);
        vec_t b;
        case (src)
            SRC_REG:  b = rd2;
            SRC_IMM:  b = ext;
            SRC_BIMM: b = {LANES{ext[0]}};
            default:  b = {LANES{rd2[0]}};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/vector_execute_unit_if.sv
// Operand/control bus between the decode/execute register, the execute stage and the execute/memory register.
interface vector_execute_unit_if;
    import vec_pkg::*;

    logic       in_valid;
    vec_t       rd1;
    vec_t       rd2;
    vec_t       extend;
    logic [1:0] ALUSrc;
    logic [2:0] ALUControl;
    logic       RegWrite;
    logic       MemtoReg;
    logic       MemWrite;
    logic [3:0] WA3;

    logic       stall;
    logic       out_valid;
    vec_t       result;
    logic       RegWriteO;
    logic       MemtoRegO;
    logic       MemWriteO;
    logic [3:0] WA3O;

    modport master (
        output in_valid, rd1, rd2, extend, ALUSrc, ALUControl,
               RegWrite, MemtoReg, MemWrite, WA3,
        input  stall, out_valid, result, RegWriteO, MemtoRegO, MemWriteO, WA3O
    );

    modport slave (
        input  in_valid, rd1, rd2, extend, ALUSrc, ALUControl,
               RegWrite, MemtoReg, MemWrite, WA3,
        output stall, out_valid, result, RegWriteO, MemtoRegO, MemWriteO, WA3O
    );

endinterface

// File: rtl/vector_execute_unit_lane_alu.sv
// Single-lane combinational ALU; wrapping arithmetic, bitwise ops and logical shifts.
module vec_lane_alu
    import vec_pkg::*;
(
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_op_e      op,
    output logic [N-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ADD:     y = a + b;
            SUB:     y = a - b;
            AND:     y = a & b;
            OR:      y = a | b;
            XOR:     y = a ^ b;
            SHL:     y = a << b[SH_W-1:0];
            SHR:     y = a >> b[SH_W-1:0];
            PASSB:   y = b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vector_execute_unit.sv
// Vector execute stage: latches one op, evaluates LPC lanes per cycle, then
// presents the full result with its forwarded write-back controls.
module vector_execute_unit
    import vec_pkg::*;
#(
    parameter int unsigned LPC = 4
) (
    input logic                  clk,
    input logic                  reset,
    vector_execute_unit_if.slave bus
);

    localparam int unsigned C     = LANES / LPC;
    localparam int unsigned CNT_W = (C > 1) ? $clog2(C) : 1;

    // Operands and result viewed as C chunks of LPC lanes so the chunk counter indexes directly.
    typedef logic [C-1:0][LPC-1:0][N-1:0] chunked_t;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    chunked_t             a_q, b_q, res_q;
    alu_op_e              op_q;
    ctrl_t                ctrl_q, ctrl_out_q;
    logic [LPC-1:0][N-1:0] lane_y;
    logic                 accept;
    logic                 last_chunk;

    assign accept     = bus.in_valid && (state_q != S_BUSY);
    assign last_chunk = (cnt_q == CNT_W'(C - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid) state_d = S_BUSY;
            S_BUSY:  if (last_chunk) state_d = S_DONE;
            S_DONE:  state_d = bus.in_valid ? S_BUSY : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.stall     = (state_q == S_BUSY);
        bus.out_valid = (state_q == S_DONE);
    end

    for (genvar j = 0; j < LPC; j++) begin : g_lane
        vec_lane_alu u_alu (
            .a  (a_q[cnt_q][j]),
            .b  (b_q[cnt_q][j]),
            .op (op_q),
            .y  (lane_y[j])
        );
    end

    // Controls reach the outputs only with the last chunk so they stay paired with a complete result.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= ADD;
            ctrl_q     <= '0;
            ctrl_out_q <= '0;
            res_q      <= '0;
        end else if (accept) begin
            cnt_q  <= '0;
            a_q    <= bus.rd1;
            b_q    <= select_b(alu_src_e'(bus.ALUSrc), bus.rd2, bus.extend);
            op_q   <= alu_op_e'(bus.ALUControl);
            ctrl_q <= {bus.RegWrite, bus.MemtoReg, bus.MemWrite, bus.WA3};
        end else if (state_q == S_BUSY) begin
            res_q[cnt_q] <= lane_y;
            cnt_q        <= last_chunk ? '0 : cnt_q + 1'b1;
            if (last_chunk) begin
                ctrl_out_q <= ctrl_q;
            end
        end
    end

    assign bus.result    = res_q;
    assign bus.RegWriteO = ctrl_out_q.reg_write;
    assign bus.MemtoRegO = ctrl_out_q.mem_to_reg;
    assign bus.MemWriteO = ctrl_out_q.mem_write;
    assign bus.WA3O      = ctrl_out_q.wa3;

endmodule

// File: tb/tb_vector_execute_unit.sv
// Self-checking bench for vector_execute_unit: directed table, hand sequences and random ops vs a lane model.
module tb_vector_execute_unit;
    import vec_pkg::*;

    localparam int W  = 8;
    localparam int M  = 256;
    localparam int NT = 12;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] r2;
        logic [7:0] ext;
        logic [1:0] src;
        logic [2:0] op;
        logic       ramp;
        logic [7:0] y;
    } vec_rec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    vector_execute_unit_if bus ();
    vector_execute_unit_if bus16 ();

    vector_execute_unit #(.LPC(4))  dut   (.clk(clk), .reset(reset), .bus(bus));
    vector_execute_unit #(.LPC(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_vec(input string name, input vec_t act, input vec_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int l = 0; l < LANES; l++) v[l] = 8'($urandom);
        return v;
    endfunction

    // Lane-by-lane reference computed with plain integer arithmetic.
    function automatic vec_t model(input vec_t a, input vec_t r2, input vec_t ext,
                                   input logic [1:0] src, input logic [2:0] op);
        vec_t r;
        int av, bv, y, sh;
        for (int l = 0; l < LANES; l++) begin
            av = int'(a[l]);
            case (src)
                2'd0:    bv = int'(r2[l]);
                2'd1:    bv = int'(ext[l]);
                2'd2:    bv = int'(ext[0]);
                default: bv = int'(r2[0]);
            endcase
            sh = bv % W;
            case (op)
                3'd0:    y = (av + bv) % M;
                3'd1:    y = (av - bv + M) % M;
                3'd2:    y = av & bv;
                3'd3:    y = av | bv;
                3'd4:    y = av ^ bv;
                3'd5:    y = (av * (1 << sh)) % M;
                3'd6:    y = av / (1 << sh);
                default: y = bv;
            endcase
            r[l] = 8'(y);
        end
        return r;
    endfunction

    task automatic drive(input vec_t a, input vec_t r2, input vec_t ext,
                         input logic [1:0] src, input logic [2:0] op, input logic [6:0] ctl);
        bus.in_valid   = 1'b1;
        bus.rd1        = a;
        bus.rd2        = r2;
        bus.extend     = ext;
        bus.ALUSrc     = src;
        bus.ALUControl = op;
        {bus.RegWrite, bus.MemtoReg, bus.MemWrite, bus.WA3} = ctl;
    endtask

    task automatic scramble(input logic iv);
        drive(rand_vec(), rand_vec(), rand_vec(), 2'($urandom), 3'($urandom), 7'($urandom));
        bus.in_valid = iv;
    endtask

    task automatic run_op(input string name, input vec_t a, input vec_t r2, input vec_t ext,
                          input logic [1:0] src, input logic [2:0] op, input logic [6:0] ctl,
                          input vec_t exp);
        int lat;
        int stalls;
        drive(a, r2, ext, src, op, ctl);
        lat    = 0;
        stalls = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
            if (bus.stall) stalls++;
            scramble(1'($urandom));
        end
        bus.in_valid = 1'b0;
        check_int({name, " latency"}, lat, 5);
        check_int({name, " stall cycles"}, stalls, 4);
        check_vec({name, " result"}, bus.result, exp);
        check_int({name, " ctrl"}, int'({bus.RegWriteO, bus.MemtoRegO, bus.MemWriteO, bus.WA3O}),
                  int'(ctl));
    endtask

    vec_rec_t   tbl [NT];
    vec_t       va, vr, ve, vexp, vexp2;
    logic [6:0] ctl;
    int         cnt;

    initial begin
        tbl[0]  = '{"wrap_add",   8'hF0, 8'h00, 8'h20, 2'b10, 3'b000, 1'b0, 8'h10};
        tbl[1]  = '{"sub_under",  8'h00, 8'h01, 8'h00, 2'b00, 3'b001, 1'b0, 8'hFF};
        tbl[2]  = '{"shl3",       8'h81, 8'h00, 8'h03, 2'b01, 3'b101, 1'b0, 8'h08};
        tbl[3]  = '{"shr3",       8'h81, 8'h00, 8'h03, 2'b01, 3'b110, 1'b0, 8'h10};
        tbl[4]  = '{"shl9",       8'h81, 8'h00, 8'h09, 2'b01, 3'b101, 1'b0, 8'h02};
        tbl[5]  = '{"shr9_breg",  8'h81, 8'h09, 8'h00, 2'b11, 3'b110, 1'b0, 8'h40};
        tbl[6]  = '{"and",        8'hF0, 8'h3C, 8'h00, 2'b00, 3'b010, 1'b0, 8'h30};
        tbl[7]  = '{"or",         8'hF0, 8'h3C, 8'h00, 2'b00, 3'b011, 1'b0, 8'hFC};
        tbl[8]  = '{"xor",        8'hF0, 8'h3C, 8'h00, 2'b00, 3'b100, 1'b0, 8'hCC};
        tbl[9]  = '{"passb_imm",  8'h11, 8'h22, 8'h5A, 2'b01, 3'b111, 1'b0, 8'h5A};
        tbl[10] = '{"bcast_reg",  8'h01, 8'h10, 8'h00, 2'b11, 3'b000, 1'b1, 8'h11};
        tbl[11] = '{"bcast_imm",  8'hFF, 8'h00, 8'h20, 2'b10, 3'b100, 1'b1, 8'hDF};

        bus.in_valid = 1'b0;
        bus.rd1 = '0; bus.rd2 = '0; bus.extend = '0; bus.ALUSrc = '0; bus.ALUControl = '0;
        {bus.RegWrite, bus.MemtoReg, bus.MemWrite, bus.WA3} = '0;
        bus16.in_valid = 1'b0;
        bus16.rd1 = '0; bus16.rd2 = '0; bus16.extend = '0; bus16.ALUSrc = '0; bus16.ALUControl = '0;
        {bus16.RegWrite, bus16.MemtoReg, bus16.MemWrite, bus16.WA3} = '0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_int("reset stall", int'(bus.stall), 0);
        check_int("reset out_valid", int'(bus.out_valid), 0);
        check_vec("reset result", bus.result, '0);
        check_int("reset ctrl", int'({bus.RegWriteO, bus.MemtoRegO, bus.MemWriteO, bus.WA3O}), 0);
        reset = 1'b0;

        // Ramp add: lane i = i + 2i.
        for (int l = 0; l < LANES; l++) begin
            va[l] = 8'(l); vr[l] = 8'(2 * l); vexp[l] = 8'(3 * l);
        end
        run_op("add_ramp", va, vr, '0, 2'b00, 3'b000, 7'b1010011, vexp);
        @(negedge clk);
        check_int("pulse width", int'(bus.out_valid), 0);

        for (int i = 0; i < NT; i++) begin
            for (int l = 0; l < LANES; l++) begin
                va[l]   = tbl[i].a;
                vr[l]   = tbl[i].ramp ? tbl[i].r2 + 8'(l) : tbl[i].r2;
                ve[l]   = tbl[i].ramp ? tbl[i].ext + 8'(l) : tbl[i].ext;
                vexp[l] = tbl[i].y;
            end
            ctl = 7'($urandom);
            run_op(tbl[i].name, va, vr, ve, tbl[i].src, tbl[i].op, ctl, vexp);
            if (i % 2 == 1) @(negedge clk);
        end

        run_op("ctrl_fwd", va, vr, ve, 2'b01, 3'b111, 7'b1001010, ve);
        check_int("fwd RegWriteO", int'(bus.RegWriteO), 1);
        check_int("fwd WA3O", int'(bus.WA3O), 10);
        @(negedge clk);

        // Back-to-back: in_valid held high through BUSY, second op accepted in DONE.
        for (int l = 0; l < LANES; l++) begin
            va[l] = 8'(l); vexp[l] = 8'(l + 1); vexp2[l] = 8'h1E;
        end
        drive(va, {LANES{8'h01}}, '0, 2'b00, 3'b000, 7'h4A);
        cnt = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (!bus.out_valid && bus.stall) cnt++;
            scramble(1'b1);
        end
        check_int("b2b op1 busy cycles", cnt, 4);
        @(negedge clk);
        check_int("b2b op1 out_valid", int'(bus.out_valid), 1);
        check_vec("b2b op1 result", bus.result, vexp);
        check_int("b2b op1 ctrl", int'({bus.RegWriteO, bus.MemtoRegO, bus.MemWriteO, bus.WA3O}), 'h4A);
        drive({LANES{8'h0F}}, '0, {LANES{8'h01}}, 2'b01, 3'b101, 7'h35);
        cnt = 0;
        for (int c = 6; c <= 9; c++) begin
            @(negedge clk);
            if (!bus.out_valid && bus.stall) cnt++;
            scramble(1'b1);
        end
        check_int("b2b op2 busy cycles", cnt, 4);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_int("b2b op2 out_valid", int'(bus.out_valid), 1);
        check_vec("b2b op2 result", bus.result, vexp2);
        check_int("b2b op2 ctrl", int'({bus.RegWriteO, bus.MemtoRegO, bus.MemWriteO, bus.WA3O}), 'h35);
        @(negedge clk);

        // Reset while chunk 2 is pending.
        drive(va, va, va, 2'b00, 3'b000, 7'h7F);
        repeat (3) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check_vec("midreset result", bus.result, '0);
        check_int("midreset WA3O", int'(bus.WA3O), 0);
        check_int("midreset stall", int'(bus.stall), 0);
        check_int("midreset out_valid", int'(bus.out_valid), 0);
        reset = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        check_int("midreset no pulse", cnt, 0);

        // Single-chunk configuration.
        for (int l = 0; l < LANES; l++) begin
            va[l] = 8'(l); vexp[l] = 8'(l - 2);
        end
        bus16.in_valid = 1'b1; bus16.rd1 = va; bus16.rd2 = {LANES{8'h02}};
        bus16.ALUSrc = 2'b00; bus16.ALUControl = 3'b001;
        {bus16.RegWrite, bus16.MemtoReg, bus16.MemWrite, bus16.WA3} = 7'h66;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        check_int("lpc16 stall", int'(bus16.stall), 1);
        check_int("lpc16 early valid", int'(bus16.out_valid), 0);
        @(negedge clk);
        check_int("lpc16 out_valid", int'(bus16.out_valid), 1);
        check_vec("lpc16 result", bus16.result, vexp);
        check_int("lpc16 ctrl", int'({bus16.RegWriteO, bus16.MemtoRegO, bus16.MemWriteO, bus16.WA3O}), 'h66);
        @(negedge clk);
        check_int("lpc16 idle", int'(bus16.out_valid | bus16.stall), 0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] src;
            logic [2:0] op;
            va  = rand_vec();
            vr  = rand_vec();
            ve  = rand_vec();
            src = 2'($urandom);
            op  = 3'($urandom);
            ctl = 7'($urandom);
            run_op($sformatf("rand%0d", i), va, vr, ve, src, op, ctl, model(va, vr, ve, src, op));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
